// File: rtl/pipe_skid_stage.sv
// Parametrised valid/ready pipeline register with a 2-entry skid buffer.
// Optional statistics counters enabled by defining PIPE_STAT_EN.
module pipe_skid_stage #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             emit;

  // ready depends only on registered state, never on out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // state and payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // next state; flush wins over every handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = in_data;
          end
        end
        HALF: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        FULL: begin
          if (emit) begin
            state_d = HALF;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flsh_q, flsh_d;
  logic [CNT_W:0]   flsh_sum;
  logic [1:0]       held;

  assign stall_cnt = stall_q;
  assign flush_cnt = flsh_q;

  // saturating statistics counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flsh_q  <= '0;
    end else begin
      stall_q <= stall_d;
      flsh_q  <= flsh_d;
    end
  end

  // count stalled cycles and entries squashed by flush
  always_comb begin
    stall_d  = stall_q;
    flsh_d   = flsh_q;
    held     = 2'd0;
    unique case (1'b1)
      (state_q == FULL): held = 2'd2;
      (state_q == HALF): held = 2'd1;
      default:           held = 2'd0;
    endcase
    flsh_sum = {1'b0, flsh_q} + (CNT_W+1)'(held);
    if (out_valid && !out_ready && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
    if (flush)
      flsh_d = flsh_sum[CNT_W] ? '1 : flsh_sum[CNT_W-1:0];
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Vector table plus queue scoreboard for pipe_skid_stage.
// Counter expectations follow PIPE_STAT_EN.
module tb_pipe_skid_stage;

  localparam int          W   = 16;
  localparam logic [15:0] BUB = 16'hDEAD;
  localparam int          CW  = 4;
  localparam int          SAT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_skid_stage #(
    .WIDTH (W),
    .BUBBLE(BUB),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [15:0] d;
    bit          orr;
    bit          fl;
    bit          eov;
    bit          eir;
    logic [15:0] eod;
  } vec_t;

  vec_t        vec [18];
  logic [15:0] mq [$];
  int          m_stall = 0;
  int          m_flush = 0;
  int          total = 0;
  int          passed = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  function automatic int exp_stall();
`ifdef PIPE_STAT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush();
`ifdef PIPE_STAT_EN
    return m_flush;
`else
    return 0;
`endif
  endfunction

  task automatic check_model(string tag);
    logic [15:0] eod;
    eod = (mq.size() > 0) ? mq[0] : BUB;
    chk({tag, "_sb_ov"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, "_sb_ir"}, 32'(in_ready), 32'(mq.size() < 2));
    chk({tag, "_sb_od"}, 32'(out_data), 32'(eod));
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall()));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush()));
    if (out_valid && out_data == 16'h0055)
      chk({tag, "_no55"}, 32'(out_data), 32'(BUB));
  endtask

  // drive at negedge, update model, sample at next negedge
  task automatic step(bit iv, logic [15:0] d, bit orr, bit fl,
                      string tag);
    int n;
    bit acc;
    bit emt;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    n   = mq.size();
    acc = iv && (n < 2);
    emt = (n > 0) && orr;
    if (n > 0 && !orr)
      m_stall = (m_stall >= SAT) ? SAT : m_stall + 1;
    if (fl) begin
      m_flush = (m_flush + n > SAT) ? SAT : m_flush + n;
      mq.delete();
    end else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    //          iv  d        or fl  eov eir eod
    vec[0]  = '{1, 16'h0011, 1, 0, 1, 1, 16'h0011};
    vec[1]  = '{1, 16'h0022, 1, 0, 1, 1, 16'h0022};
    vec[2]  = '{1, 16'h0033, 1, 0, 1, 1, 16'h0033};
    vec[3]  = '{0, 16'h0000, 1, 0, 0, 1, BUB};
    vec[4]  = '{1, 16'h00A1, 0, 0, 1, 1, 16'h00A1};
    vec[5]  = '{1, 16'h00A2, 0, 0, 1, 0, 16'h00A1};
    vec[6]  = '{1, 16'h00A3, 0, 0, 1, 0, 16'h00A1};
    vec[7]  = '{1, 16'h00A3, 1, 0, 1, 1, 16'h00A2};
    vec[8]  = '{1, 16'h00A3, 1, 0, 1, 1, 16'h00A3};
    vec[9]  = '{0, 16'h0000, 1, 0, 0, 1, BUB};
    vec[10] = '{1, 16'h00B1, 0, 0, 1, 1, 16'h00B1};
    vec[11] = '{1, 16'h00B2, 0, 0, 1, 0, 16'h00B1};
    vec[12] = '{0, 16'h0000, 0, 1, 0, 1, BUB};
    vec[13] = '{1, 16'h00C1, 0, 0, 1, 1, 16'h00C1};
    vec[14] = '{1, 16'h0055, 1, 1, 0, 1, BUB};
    vec[15] = '{0, 16'h0000, 1, 0, 0, 1, BUB};
    vec[16] = '{1, 16'h0066, 1, 0, 1, 1, 16'h0066};
    vec[17] = '{0, 16'h0000, 1, 0, 0, 1, BUB};

    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_od", 32'(out_data), 32'(BUB));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vec[i].iv, vec[i].d, vec[i].orr, vec[i].fl,
           $sformatf("v%0d", i));
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vec[i].eov));
      chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(vec[i].eir));
      chk($sformatf("v%0d_od", i), 32'(out_data), 32'(vec[i].eod));
    end
`ifdef PIPE_STAT_EN
    chk("tbl_stall", 32'(stall_cnt), 32'd4);
    chk("tbl_flush", 32'(flush_cnt), 32'd3);
`else
    chk("tbl_stall", 32'(stall_cnt), 32'd0);
    chk("tbl_flush", 32'(flush_cnt), 32'd0);
`endif

    // asynchronous reset while FULL
    step(1, 16'h00E1, 0, 0, "pre_rst0");
    step(1, 16'h00E2, 0, 0, "pre_rst1");
    chk("full_ir", 32'(in_ready), 32'd0);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_od", 32'(out_data), 32'(BUB));
    chk("arst_ir", 32'(in_ready), 32'd1);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_flush", 32'(flush_cnt), 32'd0);
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst = 1'b1;
    check_model("post_rst");

    // long stall saturates the counter
    step(1, 16'h0077, 0, 0, "sat_in");
    for (int i = 0; i < 20; i++)
      step(0, 16'h0000, 0, 0, $sformatf("sat%0d", i));
`ifdef PIPE_STAT_EN
    chk("stall_sat", 32'(stall_cnt), 32'd15);
`else
    chk("stall_sat", 32'(stall_cnt), 32'd0);
`endif
    chk("sat_od", 32'(out_data), 32'h0077);
    step(0, 16'h0000, 1, 0, "drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline stage register, the generalised successor of the fixed 32-bit IF/ID latch.
- Carries an arbitrary-width payload bundle (instruction, PC+4, control fields) between pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so backpressure does not need a combinational ready path.
- Synchronous flush inserts a configurable bubble value; used at IF/ID, ID/EX and later stage boundaries.

Parameters:
- WIDTH, 64, payload width in bits (e.g. instruction + PC_plus_4).
- BUBBLE, {WIDTH{1'b0}}, payload value driven when the stage holds no valid entry (NOP encoding).
- CNT_W, 16, width of the statistics counters (used only with PIPE_STAT_EN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all held entries (branch/jump taken).
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; equals NOT skid_valid (registered state only).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid (main entry valid).
- out_ready  input  1  downstream accepts this cycle (0 = stall).
- out_data  output  WIDTH  main entry payload; equals BUBBLE whenever out_valid=0.
- stall_cnt  output  CNT_W  stall-cycle statistic (PIPE_STAT_EN only, else constant 0).
- flush_cnt  output  CNT_W  squashed-entry statistic (PIPE_STAT_EN only, else constant 0).

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - in_valid/in_data may change freely while in_ready=0; nothing is sampled in that case.
- Reset (rst=0, asynchronous):
  - State EMPTY; main and skid data = BUBBLE.
  - out_valid=0, in_ready=1, counters=0.
- States: EMPTY (main invalid), HALF (main valid, skid empty), FULL (main and skid valid).
- EMPTY:
  - Accept -> HALF, main<=in_data.
  - Otherwise stay EMPTY.
- HALF:
  - Accept & Emit -> HALF, main<=in_data.
  - Accept only -> FULL, skid<=in_data.
  - Emit only -> EMPTY, main<=BUBBLE.
  - Neither -> hold.
- FULL:
  - in_ready=0, so Accept is impossible.
  - Emit -> HALF, main<=skid, skid<=BUBBLE.
  - Otherwise hold.
- Latency and ordering:
  - 1 cycle from Accept to out_valid when the stage was EMPTY or emitting that cycle.
  - Throughput 1 entry/cycle with out_ready held at 1.
  - Strict FIFO order; no entry is duplicated or dropped except by flush.
- flush=1 priority:
  - Overrides all transitions; next state EMPTY, main and skid <= BUBBLE.
  - Any Accept or Emit in the same cycle: the upstream beat is discarded; the downstream beat counts as delivered (downstream is responsible for its own squash).
  - in_ready=1 on the following cycle.
- Reset asserted mid-operation: immediate return to the reset values, all entries lost.
- in_ready is never a combinational function of out_ready (no ready path through the stage).

Optional Feature:
- Macro PIPE_STAT_EN.
- When defined:
  - stall_cnt increments every cycle with out_valid=1 & out_ready=0.
  - flush_cnt adds the number of valid entries squashed by flush (0, 1 or 2) per flush cycle.
  - Both counters saturate at all-ones and clear only on reset.
- When undefined: counter logic is absent; both outputs are tied to 0. Datapath behaviour is identical either way.

Test Plan:
- Reset, then in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, out_valid continuous, in_ready stays 1.
- Feed 0xA1,0xA2 while out_ready=0 -> FULL, in_ready=0 after the second accept, 0xA3 held off upstream; raise out_ready -> outputs 0xA1,0xA2,0xA3 in order, nothing lost.
- FULL state with flush=1 -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1; with PIPE_STAT_EN, flush_cnt=2.
- Flush coinciding with Accept of 0x55 -> 0x55 never appears at out_data.
- Assert rst mid-stream with FULL -> out_valid=0 and out_data=BUBBLE immediately, without waiting for a clock edge.
- PIPE_STAT_EN with CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).
